edram_port_ctrl: RTL and testbench
==================================

// Module: edram_port_ctrl
// PURPOSE
// - Initiator for one edram macro port: drives reads, writes and refreshes from a host req/rsp channel.
// - Sequences ops on the macro's 4-clk slot grid; the macro does ECC and write-back itself.
// - Sits between the cache-side requester and the edram instance.
// PARAMETERS
// - DATA_W       325  macro word width (ECC-encoded word)
// - ADDR_W       5    row address width (32 rows)
// - REF_INTERVAL 64   slots between refresh requests; must be >=2
// - RD_LAT       2    slots from issue to valid port_read_data
// PORTS
// - clk             in   1       clock
// - rst             in   1       synchronous reset, active-low
// - req_valid       in   1       host request valid
// - req_ready       out  1       host request accepted this clk
// - req_we          in   1       1=write, 0=read
// - req_addr        in   ADDR_W  row address
// - req_wdata       in   DATA_W  write data
// - rsp_valid       out  1       one-clk pulse, read data valid
// - rsp_data        out  DATA_W  read data
// - port_en         out  1       macro read/access strobe
// - port_ref_plus2  out  1       macro refresh-read strobe
// - port_read_addr  out  ADDR_W  row for port_en/port_ref_plus2
// - port_read_data  in   DATA_W  macro read data
// - port_write_addr out  ADDR_W  row for port_wen_plus3
// - port_write_data out  DATA_W  write data to macro
// - port_data       out  1       load port_write_data into macro pipe
// - port_wen_plus3  out  1       commit write to port_write_addr
// BEHAVIOUR
// - Reset (rst==0 at posedge): all outputs 0; phase=0; slot pipe, scoreboard, ref counter and ref row cleared.
// - phase counts 0..3 every clk, wrapping. A slot = 4 clk. Ops issue only at phase 0.
// - At most one op (read, write or refresh) per slot. All port_* strobes last exactly 1 clk, at phase 0.
// - Priority at phase 0:
//   - a pending refresh wins;
//   - else the host request if valid and no hazard;
//   - else idle slot.
// - req_ready=1 only at phase 0 when the host op is issued that clk (combinational from the arbitration).
// - Read at slot N:
//   - port_en=1, port_read_addr=req_addr;
//   - at slot N+RD_LAT phase 0, capture port_read_data into rsp_data, rsp_valid=1 for 1 clk.
// - Write at slot N:
//   - port_data=1, port_write_data=req_wdata at slot N;
//   - port_wen_plus3=1, port_write_addr=req_addr at slot N+3.
//   - port_write_data holds its value until the next write.
// - Refresh at slot N: port_ref_plus2=1, port_read_addr=ref_row; ref_row increments mod 2^ADDR_W.
// - ref counter counts slots. At REF_INTERVAL-1 it sets ref_pending and wraps to 0.
// - ref_pending clears when the refresh issues. A second expiry while pending sets ref_overrun (sticky, debug).
// - Hazard scoreboard:
//   - rows in flight in the last 3 slots: reads and refreshes (write-back pending), writes (commit pending);
//   - a host request to an in-flight row stalls (req_ready=0) until the row retires;
//   - the refresh row is not checked; a colliding host op waits.
// - Write commit at slot N+3 and a new issue at slot N+3 both drive the port in the same clk.
//   Both are legal; port_write_* and port_read_* are independent fields.
// - rsp ordering is issue order. No backpressure on rsp; the host must always accept.
// - Reset mid-op: in-flight ops are dropped, with no rsp and no port_wen_plus3 after reset.
// STRUCTURE
// - Shared package edram_pkg:
//   - DATA_W, ADDR_W, SLOT_CLKS=4, WB_SLOTS=3;
//   - typedef edram_op_t {IDLE, RD, WR, REF};
//   - typedef slot_ent_t {op, addr}.
// - One sub-module: edram_slot_pipe.
//   - 4-deep shift of slot_ent_t, advanced at phase 0;
//   - outputs hazard match, rd-return tap at RD_LAT, wr-commit tap at 3.
// - Top holds the phase counter, ref counter/row, arbiter and data registers.
// TESTING
// - Reset release, idle for 10 slots -> all port_* stay 0; first port_ref_plus2 at slot REF_INTERVAL-1 with addr 0.
// - Write addr 5 data D, then read addr 5 -> stall until write commits.
//   Then port_en at the next free slot and rsp_data==D.
// - Back-to-back reads to rows 1,2,3 -> one per slot; rsp_valid pulses 4 clk apart, in order.
// - Refresh due while req_valid to row 7 -> refresh issues first; host issues next slot.
//   After 32 refreshes ref_row wraps to 0.
// - Read row 9, then a host op to row 9 in the following slot -> req_ready=0 for 3 slots, issue in the 4th.
// - rst low for 1 clk between write issue and commit -> no port_wen_plus3; all outputs 0 the next clk.

Source files
------------

// File: rtl/edram_pkg.sv
// Shared widths, slot-grid constants and slot-pipe entry types for the edram port controller.
package edram_pkg;

    localparam int DATA_W    = 325;
    localparam int ADDR_W    = 5;
    localparam int SLOT_CLKS = 4;
    localparam int WB_SLOTS  = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        REF  = 2'd3
    } edram_op_t;

    typedef struct packed {
        edram_op_t         op;
        logic [ADDR_W-1:0] addr;
    } slot_ent_t;

endpackage

// File: rtl/edram_slot_pipe.sv
// History of the ops issued in recent slots: row-hazard match, read-return tap and write-commit tap.
module edram_slot_pipe
    import edram_pkg::*;
#(
    parameter int RD_LAT = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              adv_i,
    input  logic [1:0]        issue_op_i,
    input  logic [ADDR_W-1:0] issue_addr_i,
    input  logic [ADDR_W-1:0] chk_addr_i,
    output logic              hit_o,
    output logic              rd_ret_o,
    output logic              wr_commit_o,
    output logic [ADDR_W-1:0] wr_addr_o
);

    // Entry 0 of the 4-entry pipe is the op issuing this slot; only the three older ones are stored.
    slot_ent_t [WB_SLOTS-1:0] ent_q;
    slot_ent_t [WB_SLOTS-1:0] ent_d;
    slot_ent_t                issue_ent;

    always_comb begin
        issue_ent = '{op: edram_op_t'(issue_op_i), addr: issue_addr_i};
        ent_d     = ent_q;
        if (adv_i) begin
            ent_d = {ent_q[WB_SLOTS-2:0], issue_ent};
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            ent_q <= '0;
        end else begin
            ent_q <= ent_d;
        end
    end

    always_comb begin
        hit_o = 1'b0;
        for (int i = 0; i < WB_SLOTS; i++) begin
            if ((ent_q[i].op != IDLE) && (ent_q[i].addr == chk_addr_i)) begin
                hit_o = 1'b1;
            end
        end
    end

    // Stored entry k was issued k+1 slots ago, so RD_LAT must stay within 1..WB_SLOTS.
    assign rd_ret_o    = (ent_q[RD_LAT-1].op == RD);
    assign wr_commit_o = (ent_q[WB_SLOTS-1].op == WR);
    assign wr_addr_o   = ent_q[WB_SLOTS-1].addr;

endmodule

// File: rtl/edram_port_ctrl.sv
// edram macro port initiator: arbitrates refresh and host ops onto the 4-clk slot grid,
// commits writes three slots after issue and returns read data RD_LAT slots after issue.
module edram_port_ctrl
    import edram_pkg::*;
#(
    parameter int REF_INTERVAL = 64,
    parameter int RD_LAT       = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    output logic              rsp_valid_o,
    output logic [DATA_W-1:0] rsp_data_o,
    output logic              port_en_o,
    output logic              port_ref_plus2_o,
    output logic [ADDR_W-1:0] port_read_addr_o,
    input  logic [DATA_W-1:0] port_read_data_i,
    output logic [ADDR_W-1:0] port_write_addr_o,
    output logic [DATA_W-1:0] port_write_data_o,
    output logic              port_data_o,
    output logic              port_wen_plus3_o
);

    localparam int              RC_W     = $clog2(REF_INTERVAL);
    localparam logic [RC_W-1:0] REF_LAST = RC_W'(REF_INTERVAL - 1);

    logic [1:0]        phase_q, phase_d;
    logic [RC_W-1:0]   ref_cnt_q, ref_cnt_d;
    logic [ADDR_W-1:0] ref_row_q, ref_row_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_valid_q, rsp_valid_d;

    logic              slot_start;
    logic              ref_due;
    logic              host_go;
    edram_op_t         issue_op;
    logic [ADDR_W-1:0] issue_addr;
    logic              hit;
    logic              rd_ret;
    logic              wr_commit;
    logic [ADDR_W-1:0] wr_addr;

    edram_slot_pipe #(
        .RD_LAT(RD_LAT)
    ) u_slot_pipe (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .adv_i       (slot_start),
        .issue_op_i  (issue_op),
        .issue_addr_i(issue_addr),
        .chk_addr_i  (req_addr_i),
        .hit_o       (hit),
        .rd_ret_o    (rd_ret),
        .wr_commit_o (wr_commit),
        .wr_addr_o   (wr_addr)
    );

    // Refresh always wins the slot in which the interval expires, so a pending refresh never
    // outlives its slot and no separate pending/overrun state is needed.
    always_comb begin
        slot_start = rst_i && (phase_q == 2'd0);
        ref_due    = slot_start && (ref_cnt_q == REF_LAST);
        host_go    = slot_start && !ref_due && req_valid_i && !hit;
        issue_op   = IDLE;
        if (ref_due) begin
            issue_op = REF;
        end else if (host_go) begin
            issue_op = req_we_i ? WR : RD;
        end
        issue_addr = (issue_op == REF) ? ref_row_q : req_addr_i;
    end

    always_comb begin
        req_ready_o       = host_go;
        port_en_o         = (issue_op == RD);
        port_ref_plus2_o  = (issue_op == REF);
        port_data_o       = (issue_op == WR);
        port_read_addr_o  = (port_en_o || port_ref_plus2_o) ? issue_addr : '0;
        port_write_data_o = port_data_o ? req_wdata_i : wdata_q;
        port_wen_plus3_o  = slot_start && wr_commit;
        port_write_addr_o = port_wen_plus3_o ? wr_addr : '0;
        rsp_valid_o       = rsp_valid_q;
        rsp_data_o        = rsp_data_q;
    end

    always_comb begin
        phase_d   = phase_q + 2'd1;
        ref_cnt_d = ref_cnt_q;
        if (slot_start) begin
            ref_cnt_d = ref_due ? '0 : ref_cnt_q + RC_W'(1);
        end
        ref_row_d   = (issue_op == REF) ? ref_row_q + ADDR_W'(1) : ref_row_q;
        wdata_d     = (issue_op == WR) ? req_wdata_i : wdata_q;
        rsp_valid_d = slot_start && rd_ret;
        rsp_data_d  = rsp_valid_d ? port_read_data_i : rsp_data_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            phase_q     <= '0;
            ref_cnt_q   <= '0;
            ref_row_q   <= '0;
            wdata_q     <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            ref_cnt_q   <= ref_cnt_d;
            ref_row_q   <= ref_row_d;
            wdata_q     <= wdata_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

endmodule

// File: tb/tb_edram_port_ctrl.sv
// Directed bench for edram_port_ctrl with a small behavioural macro model behind the port.
module tb_edram_port_ctrl;
    import edram_pkg::*;

    localparam int REF_INTERVAL = 64;
    localparam int RD_LAT       = 2;
    localparam int RSP_LAT      = RD_LAT * SLOT_CLKS + 1;

    typedef logic [699:0] chk_t;

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        int                expWait;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              reqValid = 1'b0;
    logic              reqReady;
    logic              reqWe = 1'b0;
    logic [ADDR_W-1:0] reqAddr = '0;
    logic [DATA_W-1:0] reqWdata = '0;
    logic              rspValid;
    logic [DATA_W-1:0] rspData;
    logic              portEn;
    logic              portRef;
    logic [ADDR_W-1:0] portReadAddr;
    logic [DATA_W-1:0] portReadData;
    logic [ADDR_W-1:0] portWriteAddr;
    logic [DATA_W-1:0] portWriteData;
    logic              portData;
    logic              portWen;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int refSeen = 0;
    int wenSeen;

    logic [DATA_W-1:0] mem [32];
    logic [ADDR_W-1:0] rdA0, rdA1;
    logic [DATA_W-1:0] wq [$];
    logic [DATA_W-1:0] expQ [$];
    int                expCyc [$];
    vec_t              vecs [13];
    logic [DATA_W-1:0] dA, dB, dC, dD;

    always #5 clk = ~clk;

    edram_port_ctrl #(
        .REF_INTERVAL(REF_INTERVAL),
        .RD_LAT      (RD_LAT)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .req_valid_i      (reqValid),
        .req_ready_o      (reqReady),
        .req_we_i         (reqWe),
        .req_addr_i       (reqAddr),
        .req_wdata_i      (reqWdata),
        .rsp_valid_o      (rspValid),
        .rsp_data_o       (rspData),
        .port_en_o        (portEn),
        .port_ref_plus2_o (portRef),
        .port_read_addr_o (portReadAddr),
        .port_read_data_i (portReadData),
        .port_write_addr_o(portWriteAddr),
        .port_write_data_o(portWriteData),
        .port_data_o      (portData),
        .port_wen_plus3_o (portWen)
    );

    function automatic logic [DATA_W-1:0] pat(input int unsigned s);
        logic [DATA_W-1:0] v;
        v = '0;
        for (int i = 0; i < 11; i++) begin
            v = {v[DATA_W-33:0], s * 32'h9E37_79B1 + 32'(i)};
        end
        return v;
    endfunction

    function automatic chk_t allOut();
        return chk_t'({reqReady, rspValid, rspData, portEn, portRef, portReadAddr,
                       portWriteAddr, portWriteData, portData, portWen});
    endfunction

    task automatic checkOutput(input string name, input chk_t act, input chk_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Clock count since reset; cyc % 4 is the slot phase and cyc / 4 the slot number.
    always @(posedge clk) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    // Macro model: read data appears RD_LAT slots after port_en, writes land at port_wen_plus3.
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) mem[i] <= pat(i);
            rdA0 <= '0;
            rdA1 <= '0;
            wq.delete();
        end else if (cyc % 4 == 0) begin
            rdA1 <= rdA0;
            if (portEn) rdA0 <= portReadAddr;
            if (portData) wq.push_back(portWriteData);
            if (portWen && wq.size() > 0) mem[portWriteAddr] <= wq.pop_front();
        end
    end

    assign portReadData = mem[rdA1];

    always @(negedge clk) begin
        if (rst && rspValid) begin
            if (expQ.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL rsp_unexpected: got rsp_valid=1 at cyc %0d, expected none", cyc);
            end else begin
                checkOutput("rsp_data", chk_t'(rspData), chk_t'(expQ.pop_front()));
                checkOutput("rsp_latency", chk_t'(cyc - expCyc.pop_front()), chk_t'(RSP_LAT));
            end
        end
    end

    always @(negedge clk) begin
        if (rst && portRef) begin
            checkOutput("ref_cycle", chk_t'(cyc),
                        chk_t'(SLOT_CLKS * (REF_INTERVAL - 1 + REF_INTERVAL * refSeen)));
            checkOutput("ref_row", chk_t'(portReadAddr), chk_t'(refSeen % 32));
            refSeen++;
        end
    end

    always @(negedge clk) begin
        if (rst && (cyc % 4 != 0)) begin
            checkOutput("strobe_off_phase0", chk_t'({reqReady, portEn, portRef, portData, portWen}), '0);
        end
    end

    task automatic waitPhase0();
        @(negedge clk);
        while (cyc % 4 != 0) @(negedge clk);
    endtask

    task automatic gotoSlot(input int s);
        @(negedge clk);
        while (cyc < SLOT_CLKS * s) @(negedge clk);
        if (cyc != SLOT_CLKS * s) begin
            total++;
            bad++;
            $display("[TB] FAIL goto_slot: got cyc %0d, expected %0d", cyc, SLOT_CLKS * s);
        end
    endtask

    // Presents one host op at a phase-0 negedge and holds it until accepted.
    task automatic applyStimulus(input logic we, input logic [ADDR_W-1:0] addr,
                                 input logic [DATA_W-1:0] data, input int expWait, input string name);
        int  waited;
        bit  done;
        waited   = 0;
        done     = 0;
        reqValid = 1'b1;
        reqWe    = we;
        reqAddr  = addr;
        reqWdata = we ? data : '0;
        while (!done) begin
            #1;
            if (reqReady) begin
                if (we) begin
                    checkOutput({name, "_wr_strobe"}, chk_t'({portData, portEn, portWriteData}),
                                chk_t'({1'b1, 1'b0, data}));
                end else begin
                    checkOutput({name, "_rd_strobe"}, chk_t'({portEn, portData, portReadAddr}),
                                chk_t'({1'b1, 1'b0, addr}));
                    expQ.push_back(data);
                    expCyc.push_back(cyc);
                end
                done = 1;
            end else begin
                waited++;
                if (waited > 20) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL %s_timeout: got no req_ready in %0d slots, expected %0d", name, waited, expWait);
                    done = 1;
                end else begin
                    repeat (SLOT_CLKS) @(negedge clk);
                end
            end
        end
        checkOutput({name, "_wait"}, chk_t'(waited), chk_t'(expWait));
        @(posedge clk);
        #1;
        reqValid = 1'b0;
    endtask

    initial begin
        #150000;
        $display("[TB] FAIL watchdog: got no finish by time %0t, expected finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        dA = pat(1000);
        dB = pat(2000);
        dC = pat(3000);
        dD = pat(4000);
        vecs[0]  = '{1'b1, 5'd5,  dA,      0};
        vecs[1]  = '{1'b0, 5'd5,  dA,      3};
        vecs[2]  = '{1'b0, 5'd1,  pat(1),  0};
        vecs[3]  = '{1'b0, 5'd2,  pat(2),  0};
        vecs[4]  = '{1'b0, 5'd3,  pat(3),  0};
        vecs[5]  = '{1'b1, 5'd2,  dB,      2};
        vecs[6]  = '{1'b0, 5'd2,  dB,      3};
        vecs[7]  = '{1'b0, 5'd9,  pat(9),  0};
        vecs[8]  = '{1'b1, 5'd9,  dC,      3};
        vecs[9]  = '{1'b0, 5'd0,  pat(0),  0};
        vecs[10] = '{1'b1, 5'd31, dD,      0};
        vecs[11] = '{1'b0, 5'd31, dD,      3};
        vecs[12] = '{1'b0, 5'd9,  dC,      0};

        // Reset held with a request asserted: every output must stay low.
        reqValid = 1'b1;
        reqAddr  = 5'd3;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_outputs", allOut(), '0);
        reqValid = 1'b0;
        rst      = 1'b1;

        for (int i = 0; i < 10 * SLOT_CLKS; i++) begin
            #1;
            checkOutput("idle_ports", chk_t'({portEn, portRef, portReadAddr, portWriteAddr,
                                              portData, portWen, portWriteData}), '0);
            @(negedge clk);
        end

        while (cyc < SLOT_CLKS * REF_INTERVAL) @(negedge clk);
        checkOutput("first_ref_count", chk_t'(refSeen), chk_t'(1));

        gotoSlot(66);
        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].expWait,
                          $sformatf("vec%0d", i));
            waitPhase0();
        end

        // Refresh due in the same slot as a host read: refresh first, host one slot later.
        gotoSlot(2 * REF_INTERVAL - 1);
        applyStimulus(1'b0, 5'd7, pat(7), 1, "ref_vs_host");

        // Host read of the row being refreshed waits out the refresh write-back too.
        gotoSlot(3 * REF_INTERVAL - 1);
        applyStimulus(1'b0, 5'd2, dB, 1 + WB_SLOTS, "ref_row_collide");

        while (refSeen < 33 && cyc < 8600) @(negedge clk);
        checkOutput("ref_wrap_count", chk_t'(refSeen), chk_t'(33));
        checkOutput("rsp_all_returned", chk_t'(expQ.size()), '0);

        // Reset between a write issue and its commit drops the write.
        gotoSlot(2113);
        applyStimulus(1'b1, 5'd4, pat(5000), 0, "pre_reset_wr");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("post_reset_outputs", allOut(), '0);
        wenSeen = 0;
        repeat (6 * SLOT_CLKS) begin
            @(negedge clk);
            if (portWen) wenSeen++;
        end
        checkOutput("post_reset_no_commit", chk_t'(wenSeen), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
